operand_feeder: RTL

Upstream feeder for the two-operand evaluation stage. Accepts operand pairs and a per-pair kernel-mode bit over a valid/ready stream and buffers them in a small FIFO. Issues at most one pair per cycle as registered `data_in1` / `data_in2` / `kernel_enable`. Drives a registered clock-gate enable `gate_en` that keeps the evaluation stage clocked only while pairs are issuing and while its pipeline drains.

---
 rtl/operand_feeder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/operand_feeder.sv
// rtl/operand_feeder.sv - operand pair FIFO with registered issue and clock-gate enable (option: FEEDER_BUBBLE_ZERO_EN)
module operand_feeder #(
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_a,
    input  logic [7:0]                 in_b,
    input  logic                       in_mode,
    input  logic                       hold,
    output logic [7:0]                 data_in1,
    output logic [7:0]                 data_in2,
    output logic                       kernel_enable,
    output logic                       issue_valid,
    output logic                       gate_en,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [2:0]    DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      drain_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [16:0]     mem [DEPTH];

    logic push;
    logic pop;

    // Accept only when a slot is free right now; a same-cycle pop never frees a slot early.
    assign in_ready = (count < FULL_COUNT) && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !hold;

    // Storage array; contents need no reset because pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_mode, in_b, in_a};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered issue outputs; bubble cycles either clear or hold the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_in1      <= '0;
            data_in2      <= '0;
            kernel_enable <= 1'b0;
            issue_valid   <= 1'b0;
        end else if (pop) begin
            data_in1      <= mem[rd_ptr][7:0];
            data_in2      <= mem[rd_ptr][15:8];
            kernel_enable <= mem[rd_ptr][16];
            issue_valid   <= 1'b1;
        end else begin
            issue_valid   <= 1'b0;
`ifdef FEEDER_BUBBLE_ZERO_EN
            data_in1      <= '0;
            data_in2      <= '0;
            kernel_enable <= 1'b0;
`else
            data_in1      <= data_in1;
            data_in2      <= data_in2;
            kernel_enable <= kernel_enable;
`endif
        end
    end

    // Clock-gate FSM; gate_en is registered from the next state so it rises with the first issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            gate_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= RUN;
                        gate_en <= 1'b1;
                    end else begin
                        gate_en <= 1'b0;
                    end
                end
                RUN: begin
                    gate_en <= 1'b1;
                    if (!pop) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        state   <= RUN;
                        gate_en <= 1'b1;
                    end else if (drain_cnt == 3'd0) begin
                        state   <= IDLE;
                        gate_en <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                        gate_en   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gate_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
